bridge_gate_driver: RTL and testbench



---
 rtl/bridge_pkg.sv | 43 ++++
 rtl/bridge_gate_driver_leg.sv | 82 ++++++++
 rtl/bridge_gate_driver.sv | 85 ++++++++
 tb/tb_bridge_gate_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the full-bridge gate driver: leg states,
// applied-sigma encodings, command bit positions and the per-leg request decoder.
`timescale 1ns/1ps
package bridge_pkg;

   typedef enum logic [1:0] {
      LEG_OFF  = 2'd0,
      LEG_HIGH = 2'd1,
      LEG_LOW  = 2'd2
   } leg_state_e;

   localparam logic [1:0] SIG_POS  = 2'b01;
   localparam logic [1:0] SIG_ZERO = 2'b00;
   localparam logic [1:0] SIG_NEG  = 2'b11;
   localparam logic [1:0] SIG_OFF  = 2'b10;

   localparam int NUM_LEGS  = 2;
   localparam int LEG_A     = 0;
   localparam int LEG_B     = 1;
   localparam int A_HI_IDX  = 0;
   localparam int B_HI_IDX  = 1;
   localparam int A_LO_IDX  = 2;
   localparam int B_LO_IDX  = 3;
   // Low-side bit of leg n sits this many positions above its high-side bit.
   localparam int LO_OFFSET = A_LO_IDX - A_HI_IDX;

   typedef struct packed {
      leg_state_e req;
      logic       illegal;
   } leg_req_t;

   function automatic leg_req_t decode_leg(input logic hi, input logic lo);
      leg_req_t r;
      r.illegal = hi & lo;
      case ({hi, lo})
         2'b10:   r.req = LEG_HIGH;
         2'b01:   r.req = LEG_LOW;
         default: r.req = LEG_OFF;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bridge_gate_driver_leg.sv
// One half-bridge leg: OFF/HIGH/LOW state machine with a saturating dead-time
// counter (runs while OFF) and a saturating minimum-on counter (runs while conducting).
`timescale 1ns/1ps
module bridge_leg_fsm
   import bridge_pkg::*;
#(
   parameter int DEADTIME = 50,
   parameter int MIN_ON   = 10,
   parameter int CNT_W    = 8
) (
   input  logic       i_clock,
   input  logic       i_RESET,
   input  logic       i_force_off,
   input  leg_state_e i_req,
   output leg_state_e o_state
);

   localparam logic [CNT_W-1:0] DEAD_SAT  = CNT_W'(DEADTIME);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME - 1);
   localparam logic [CNT_W-1:0] ON_SAT    = CNT_W'(MIN_ON);
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);

   leg_state_e       state_q, state_d;
   logic [CNT_W-1:0] off_cnt_q, off_cnt_d;
   logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
   logic             dead_done;
   logic             on_done;

   // Counters hold the number of completed cycles in the current state, so the
   // edge that completes the interval is the one allowed to change state.
   assign dead_done = (off_cnt_q >= DEAD_LAST);
   assign on_done   = (on_cnt_q >= ON_LAST);

   always_comb begin
      state_d   = state_q;
      off_cnt_d = off_cnt_q;
      on_cnt_d  = on_cnt_q;
      if (i_force_off) begin
         state_d   = LEG_OFF;
         off_cnt_d = '0;
         on_cnt_d  = '0;
      end else begin
         case (state_q)
            LEG_OFF: begin
               if (dead_done && (i_req != LEG_OFF)) begin
                  state_d  = i_req;
                  on_cnt_d = '0;
               end else if (off_cnt_q != DEAD_SAT) begin
                  off_cnt_d = off_cnt_q + 1'b1;
               end
            end
            LEG_HIGH, LEG_LOW: begin
               if ((i_req != state_q) && on_done) begin
                  state_d   = LEG_OFF;
                  off_cnt_d = '0;
               end else if (on_cnt_q != ON_SAT) begin
                  on_cnt_d = on_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d   = LEG_OFF;
               off_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_RESET) begin
         state_q   <= LEG_OFF;
         off_cnt_q <= '0;
         on_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         off_cnt_q <= off_cnt_d;
         on_cnt_q  <= on_cnt_d;
      end
   end

   assign o_state = state_q;

endmodule

// File: rtl/bridge_gate_driver.sv
// Gate-drive back end: registers the MOSFET command, runs one dead-time/min-on
// FSM per leg, latches illegal commands as a sticky fault and decodes the gates.
`timescale 1ns/1ps
module bridge_gate_driver
   import bridge_pkg::*;
#(
   parameter int DEADTIME = 50,
   parameter int MIN_ON   = 10,
   parameter int CNT_W    = 8
) (
   input  logic       i_clock,
   input  logic       i_RESET,
   input  logic [3:0] i_MOSFET,
   input  logic       i_enable,
   output logic [3:0] o_gate,
   output logic [1:0] o_sigma_applied,
   output logic       o_fault,
   output logic       o_busy
);

   logic [3:0]          cmd_q, cmd_d;
   logic                fault_q, fault_d;
   logic                force_off;
   leg_req_t            leg_req   [NUM_LEGS];
   leg_state_e          leg_state [NUM_LEGS];
   logic [NUM_LEGS-1:0] leg_illegal;
   logic [NUM_LEGS-1:0] leg_waiting;
   logic [NUM_LEGS-1:0] gate_hi;
   logic [NUM_LEGS-1:0] gate_lo;

   always_comb begin
      cmd_d   = i_MOSFET;
      fault_d = fault_q | (|leg_illegal);
   end

   always_ff @(posedge i_clock) begin
      if (!i_RESET) begin
         cmd_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         cmd_q   <= cmd_d;
         fault_q <= fault_d;
      end
   end

   // An illegal request shuts both legs down on the same edge that latches the fault.
   assign force_off = !i_enable || fault_q || (|leg_illegal);

   for (genvar gi = 0; gi < NUM_LEGS; gi++) begin : g_leg
      assign leg_req[gi]     = decode_leg(cmd_q[gi], cmd_q[gi + LO_OFFSET]);
      assign leg_illegal[gi] = leg_req[gi].illegal;

      bridge_leg_fsm #(
         .DEADTIME (DEADTIME),
         .MIN_ON   (MIN_ON),
         .CNT_W    (CNT_W)
      ) u_leg (
         .i_clock     (i_clock),
         .i_RESET     (i_RESET),
         .i_force_off (force_off),
         .i_req       (leg_req[gi].req),
         .o_state     (leg_state[gi])
      );

      assign gate_hi[gi]     = (leg_state[gi] == LEG_HIGH);
      assign gate_lo[gi]     = (leg_state[gi] == LEG_LOW);
      assign leg_waiting[gi] = (leg_state[gi] == LEG_OFF) && (leg_req[gi].req != LEG_OFF);
   end

   always_comb begin
      o_sigma_applied = SIG_ZERO;
      if ((leg_state[LEG_A] == LEG_OFF) || (leg_state[LEG_B] == LEG_OFF)) begin
         o_sigma_applied = SIG_OFF;
      end else if ((leg_state[LEG_A] == LEG_HIGH) && (leg_state[LEG_B] == LEG_LOW)) begin
         o_sigma_applied = SIG_POS;
      end else if ((leg_state[LEG_A] == LEG_LOW) && (leg_state[LEG_B] == LEG_HIGH)) begin
         o_sigma_applied = SIG_NEG;
      end
   end

   assign o_gate  = {gate_lo, gate_hi};
   assign o_fault = fault_q;
   assign o_busy  = i_RESET && !force_off && (|leg_waiting);

endmodule

// File: tb/tb_bridge_gate_driver.sv
// Scoreboard bench for bridge_gate_driver: an edge-indexed reference model pushes the
// expected outputs of every clock edge; a monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_bridge_gate_driver;

   localparam int DT = 4;
   localparam int MO = 2;

   logic       clk;
   logic       rst_n;
   logic [3:0] mosfet;
   logic       enable;
   logic [3:0] o_gate;
   logic [1:0] o_sigma;
   logic       o_fault;
   logic       o_busy;

   bridge_gate_driver #(.DEADTIME(DT), .MIN_ON(MO), .CNT_W(8)) dut (
      .i_clock         (clk),
      .i_RESET         (rst_n),
      .i_MOSFET        (mosfet),
      .i_enable        (enable),
      .o_gate          (o_gate),
      .o_sigma_applied (o_sigma),
      .o_fault         (o_fault),
      .o_busy          (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         edge_n;
      logic [3:0] gate;
      logic [1:0] sigma;
      logic       fault;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   started = 0;

   // Reference model: each leg is 0=off, 1=high-side on, 2=low-side on, and is
   // described by the edge it last switched off / on rather than by counters.
   int         st [2];
   int         off_edge [2];
   int         on_edge [2];
   logic [3:0] m_cmd = 4'b0;
   bit         m_fault = 0;
   int         edge_n = 0;

   function automatic int leg_req(input logic [3:0] c, input int l);
      logic hi, lo;
      hi = c[l];
      lo = c[l + 2];
      if (hi && lo) return 3;
      if (hi) return 1;
      if (lo) return 2;
      return 0;
   endfunction

   task automatic model_edge(input logic [3:0] mos, input logic en, input logic rst);
      int  req_pre [2];
      bit  ill, frc, any_wait;
      exp_t e;
      if (!rst) begin
         for (int l = 0; l < 2; l++) begin
            st[l] = 0;
            off_edge[l] = edge_n;
            on_edge[l] = edge_n;
         end
         m_cmd = 4'b0;
         m_fault = 0;
      end else begin
         ill = 0;
         for (int l = 0; l < 2; l++) begin
            req_pre[l] = leg_req(m_cmd, l);
            if (req_pre[l] == 3) ill = 1;
         end
         frc = !en || m_fault || ill;
         m_fault = m_fault || ill;
         for (int l = 0; l < 2; l++) begin
            if (frc) begin
               st[l] = 0;
               off_edge[l] = edge_n;
            end else if (st[l] == 0) begin
               if (req_pre[l] != 0 && edge_n >= off_edge[l] + DT) begin
                  st[l] = req_pre[l];
                  on_edge[l] = edge_n;
               end
            end else if (req_pre[l] != st[l] && edge_n >= on_edge[l] + MO) begin
               st[l] = 0;
               off_edge[l] = edge_n;
            end
         end
         m_cmd = mos;
      end
      e.edge_n = edge_n;
      e.gate = {st[1] == 2, st[0] == 2, st[1] == 1, st[0] == 1};
      if (st[0] == 0 || st[1] == 0)      e.sigma = 2'b10;
      else if (st[0] == 1 && st[1] == 2) e.sigma = 2'b01;
      else if (st[0] == 2 && st[1] == 1) e.sigma = 2'b11;
      else                               e.sigma = 2'b00;
      e.fault = m_fault;
      ill = (leg_req(m_cmd, 0) == 3) || (leg_req(m_cmd, 1) == 3);
      frc = !rst || !en || m_fault || ill;
      any_wait = 0;
      for (int l = 0; l < 2; l++)
         if (st[l] == 0 && leg_req(m_cmd, l) != 0) any_wait = 1;
      e.busy = !frc && any_wait;
      exp_q.push_back(e);
      edge_n++;
   endtask

   task automatic step(input logic [3:0] mos, input logic en, input logic rst);
      @(negedge clk);
      mosfet = mos;
      enable = en;
      rst_n  = rst;
      model_edge(mos, en, rst);
      started = 1;
   endtask

   int seg_n = 0;
   task automatic segment(input logic [3:0] mos, input logic en, input logic rst, input int len);
      $display("seg %0d cmd %b en %0d rst %0d cycles %0d", seg_n, mos, en, rst, len);
      seg_n++;
      for (int i = 0; i < len; i++) step(mos, en, rst);
   endtask

   // Monitor: one expected entry per clock edge, compared 1 ns after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (started) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty at %0t got none required entry", $time);
            end else begin
               e = exp_q.pop_front();
               checks += 3;
               if (o_gate !== e.gate) begin
                  errors++;
                  $display("FAIL gate edge %0d got %b required %b", e.edge_n, o_gate, e.gate);
               end
               if (o_sigma !== e.sigma) begin
                  errors++;
                  $display("FAIL sigma edge %0d got %b required %b", e.edge_n, o_sigma, e.sigma);
               end
               if (o_fault !== e.fault) begin
                  errors++;
                  $display("FAIL fault edge %0d got %b required %b", e.edge_n, o_fault, e.fault);
               end
               if (o_busy !== e.busy) begin
                  errors++;
                  $display("FAIL busy edge %0d got %b required %b", e.edge_n, o_busy, e.busy);
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] c;
      int r;
      mosfet = 4'b0;
      enable = 1'b1;
      rst_n  = 1'b0;
      // Directed scenarios
      segment(4'b1001, 1, 0, 3);
      segment(4'b1001, 1, 1, 10);
      segment(4'b0110, 1, 1, 10);
      segment(4'b1001, 1, 1, 8);
      segment(4'b0011, 1, 1, 8);
      segment(4'b0110, 1, 1, 8);
      segment(4'b1001, 1, 1, 1);
      segment(4'b0110, 1, 1, 6);
      segment(4'b1001, 1, 1, 1);
      segment(4'b0110, 1, 1, 8);
      segment(4'b0101, 1, 1, 1);
      segment(4'b1001, 1, 1, 6);
      segment(4'b1001, 1, 0, 2);
      segment(4'b1001, 1, 1, 9);
      segment(4'b1001, 0, 1, 3);
      segment(4'b1001, 1, 1, 8);
      segment(4'b0110, 1, 1, 2);
      segment(4'b0110, 0, 1, 2);
      segment(4'b0110, 1, 1, 8);
      segment(4'b1010, 0, 1, 1);
      segment(4'b1001, 1, 0, 2);
      // Randomized segments
      for (int s = 0; s < 250; s++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            segment(4'($urandom_range(0, 15)), 1, 0, $urandom_range(1, 3));
         end else if (r < 8) begin
            c = 4'($urandom_range(0, 15));
            c = c | (($urandom_range(0, 1) == 0) ? 4'b0101 : 4'b1010);
            segment(c, 1'($urandom_range(0, 1)), 1, $urandom_range(1, 2));
            segment(4'b1001, 1, 1, 3);
            segment(4'b1001, 1, 0, 1);
         end else if (r < 18) begin
            segment(4'($urandom_range(0, 15)) & 4'b0011, 0, 1, $urandom_range(1, 6));
         end else begin
            c = 4'($urandom_range(0, 15));
            if (c[0] && c[2]) c[2] = 1'b0;
            if (c[1] && c[3]) c[3] = 1'b0;
            segment(c, 1, 1, $urandom_range(1, 12));
         end
      end
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d entries left required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
